// File: rtl/main_input_conditioner.sv
// main_input_conditioner
//   Conditions the raw asynchronous 'main' pin for the Moore sequence
//   detector. raw_in passes through a SYNC_STAGES-deep synchroniser. A
//   change of level is accepted only after DEBOUNCE_CYCLES consecutive
//   samples at the new level. Each accepted change raises a one-cycle
//   rise or fall pulse in the same cycle that main first shows the new
//   level.
//
//   Optional feature: define GLITCH_COUNT_EN to add a saturating counter
//   of rejected candidate changes, with a synchronous clear input.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   raw_in      in   unsynchronised input pin
//   main        out  debounced level
//   rise        out  one-cycle pulse when main goes 0->1
//   fall        out  one-cycle pulse when main goes 1->0
//   busy        out  high while a candidate change is qualifying
//   glitch_clr  in   synchronous clear of glitch_cnt (GLITCH_COUNT_EN only)
//   glitch_cnt  out  rejected-change count (GLITCH_COUNT_EN only)
module main_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8,
    parameter int GLITCH_CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    raw_in,
    output logic                    main,
    output logic                    rise,
    output logic                    fall,
`ifdef GLITCH_COUNT_EN
    input  logic                    glitch_clr,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q_s;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nx_s;
    logic                   main_r;
    logic                   main_nx_s;
    logic                   rise_r;
    logic                   rise_nx_s;
    logic                   fall_r;
    logic                   fall_nx_s;
    logic                   busy_r;
    logic                   busy_nx_s;

    // Synchroniser shift chain; only its last stage is used downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_q_s = sync_r[SYNC_STAGES-1];

    // Next-state and next-output logic of the debounce FSM.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        main_nx_s  = main_r;
        rise_nx_s  = 1'b0;
        fall_nx_s  = 1'b0;
        case (state_r)
            IDLE_LO: begin
                if (sync_q_s) begin
                    state_nx_s = CHK_HI;
                    cnt_nx_s   = CNT_ONE;
                end else begin
                    cnt_nx_s   = CNT_ZERO;
                end
            end
            CHK_HI: begin
                if (!sync_q_s) begin
                    state_nx_s = IDLE_LO;
                    cnt_nx_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx_s = IDLE_HI;
                    main_nx_s  = 1'b1;
                    rise_nx_s  = 1'b1;
                    cnt_nx_s   = CNT_ZERO;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!sync_q_s) begin
                    state_nx_s = CHK_LO;
                    cnt_nx_s   = CNT_ONE;
                end else begin
                    cnt_nx_s   = CNT_ZERO;
                end
            end
            CHK_LO: begin
                if (sync_q_s) begin
                    state_nx_s = IDLE_HI;
                    cnt_nx_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx_s = IDLE_LO;
                    main_nx_s  = 1'b0;
                    fall_nx_s  = 1'b1;
                    cnt_nx_s   = CNT_ZERO;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = IDLE_LO;
                cnt_nx_s   = CNT_ZERO;
                main_nx_s  = 1'b0;
            end
        endcase
        // busy follows the state being entered so it stays aligned with it.
        busy_nx_s = (state_nx_s == CHK_HI) || (state_nx_s == CHK_LO);
    end

    // State, counter and registered outputs; reset abandons any candidate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE_LO;
            cnt_r   <= CNT_ZERO;
            main_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            main_r  <= main_nx_s;
            rise_r  <= rise_nx_s;
            fall_r  <= fall_nx_s;
            busy_r  <= busy_nx_s;
        end
    end

    assign main = main_r;
    assign rise = rise_r;
    assign fall = fall_r;
    assign busy = busy_r;

`ifdef GLITCH_COUNT_EN
    localparam logic [GLITCH_CNT_W-1:0] GCNT_ZERO = {GLITCH_CNT_W{1'b0}};
    localparam logic [GLITCH_CNT_W-1:0] GCNT_ONE  = {{(GLITCH_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GLITCH_CNT_W-1:0] GCNT_MAX  = {GLITCH_CNT_W{1'b1}};

    logic                    glitch_s;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_r;

    // A glitch is a qualifying candidate that falls back to its idle level.
    assign glitch_s = ((state_r == CHK_HI) && !sync_q_s) ||
                      ((state_r == CHK_LO) &&  sync_q_s);

    // Saturating glitch counter; the clear has priority over a new event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_cnt_r <= GCNT_ZERO;
        end else if (glitch_clr) begin
            glitch_cnt_r <= GCNT_ZERO;
        end else if (glitch_s && (glitch_cnt_r != GCNT_MAX)) begin
            glitch_cnt_r <= glitch_cnt_r + GCNT_ONE;
        end else begin
            glitch_cnt_r <= glitch_cnt_r;
        end
    end

    assign glitch_cnt = glitch_cnt_r;
`endif

endmodule
